muldiv_issue_ctrl: RTL and testbench

- Pipeline-side initiator for the multicycle multiply/divide units: accepts a MULT/DIV from the execute stage and latches its operands and destination register.
- Issues a one-cycle ctrl_MULT/ctrl_DIV start pulse and holds the operands stable for the whole operation, because the units read them combinationally every cycle.
- Stalls the pipeline until data_resultRDY, then produces a one-cycle writeback.
- A unit exception, or a watchdog timeout, is redirected to the status register $rstatus.

---
 rtl/muldiv_issue_ctrl_pkg.sv | 17 +
 rtl/dffe_ref.sv | 20 ++
 rtl/muldiv_timeout_counter.sv | 24 ++
 rtl/muldiv_issue_ctrl.sv | 116 +++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller: FSM encoding
// and the $rstatus exception writeback constants.
package muldiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam int RSTATUS_REG   = 30;
  localparam int MULT_EXC_CODE = 4;
  localparam int DIV_EXC_CODE  = 5;
  localparam int TIMER_W       = 6;

endpackage

// File: rtl/dffe_ref.sv
// Enabled register cell with synchronous clear, used for the operand, rd and
// result holding registers.
module dffe_ref #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             en,
  input  logic             clr
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/muldiv_timeout_counter.sv
// Watchdog for the BUSY state: clears while the unit is not running, counts
// once per BUSY cycle and flags the terminal count.
module muldiv_timeout_counter
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int TERMINAL = 39
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) count <= '0;
    else if (inc)     count <= count + 1'b1;
  end

  assign tc = (count == TIMER_W'(TERMINAL));

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the multicycle multiply/divide units: latches the
// X-stage operands, pulses the unit start, stalls until the result, then writes back.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             is_mult,
  input  logic             is_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] x_operandA,
  input  logic [WIDTH-1:0] x_operandB,
  input  logic [4:0]       x_rd,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_operandA,
  output logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH-1:0] data_result,
  input  logic             data_exception,
  input  logic             data_resultRDY,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy
);

  state_t           state, state_nxt;
  logic             accept, issue, capture, timer_tc;
  logic             op_div_q, exc_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] res_q;

  assign accept  = op_valid & (is_mult | is_div) & ~flush;
  assign issue   = (state == IDLE) & accept;
  assign capture = (state == BUSY) & ~flush & (data_resultRDY | timer_tc);

  // Operands are the units' live inputs, so they only load on a new issue.
  dffe_ref #(.WIDTH(WIDTH)) u_opa (.q(data_operandA), .d(x_operandA), .clk(clock), .en(issue), .clr(reset));
  dffe_ref #(.WIDTH(WIDTH)) u_opb (.q(data_operandB), .d(x_operandB), .clk(clock), .en(issue), .clr(reset));
  dffe_ref #(.WIDTH(5))     u_rd  (.q(rd_q),          .d(x_rd),       .clk(clock), .en(issue), .clr(reset));
  dffe_ref #(.WIDTH(1))     u_div (.q(op_div_q),      .d(is_div),     .clk(clock), .en(issue), .clr(reset));

  // A timeout has no resultRDY, which routes it down the exception path.
  dffe_ref #(.WIDTH(WIDTH)) u_res (.q(res_q), .d(data_result), .clk(clock), .en(capture), .clr(reset));
  dffe_ref #(.WIDTH(1))     u_exc (.q(exc_q), .d(data_exception | ~data_resultRDY),
                                   .clk(clock), .en(capture), .clr(reset));

  muldiv_timeout_counter #(.TERMINAL(TIMEOUT - 1)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (state != BUSY),
    .inc   (state == BUSY),
    .tc    (timer_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = flush ? IDLE : BUSY;
      BUSY: begin
        if (flush)        state_nxt = IDLE;
        else if (capture) state_nxt = WB;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    case (state)
      IDLE:  stall = accept & ~reset;
      START: begin
        stall     = 1'b1;
        busy      = 1'b1;
        ctrl_DIV  = op_div_q;
        ctrl_MULT = ~op_div_q;
      end
      BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      WB: begin
        wb_valid = 1'b1;
        if (exc_q) begin
          wb_rd   = 5'(RSTATUS_REG);
          wb_data = op_div_q ? WIDTH'(DIV_EXC_CODE) : WIDTH'(MULT_EXC_CODE);
        end else begin
          wb_rd   = rd_q;
          wb_data = res_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench for muldiv_issue_ctrl: a procedural unit model plus a
// cycle-timeline reference derived from accept/pulse/ready/timeout rules.
module tb_muldiv_issue_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;

  logic             clock = 1'b0;
  logic             reset;
  logic             op_valid, is_mult, is_div, flush;
  logic [WIDTH-1:0] x_operandA, x_operandB;
  logic [4:0]       x_rd;
  logic             ctrl_MULT, ctrl_DIV;
  logic [WIDTH-1:0] data_operandA, data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception, data_resultRDY;
  logic             stall, wb_valid, busy;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;

  int n_vec = 0;
  int n_err = 0;

  muldiv_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .op_valid       (op_valid),
    .is_mult        (is_mult),
    .is_div         (is_div),
    .flush          (flush),
    .x_operandA     (x_operandA),
    .x_operandB     (x_operandB),
    .x_rd           (x_rd),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .busy           (busy)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_now();
    return {27'b0, stall, busy, ctrl_MULT, ctrl_DIV, wb_valid};
  endfunction

  // Status word: {stall, busy, ctrl_MULT, ctrl_DIV, wb_valid}
  function automatic logic [31:0] st(input bit s, input bit b, input bit m, input bit d, input bit w);
    return {27'b0, s, b, m, d, w};
  endfunction

  // One instruction from accept attempt to idle. lat < 0 means the unit never answers.
  task automatic run_op(input bit div, input bit both, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input bit force_exc,
                        input int flush_in, input int reset_in, input bit stale);
    logic [31:0] res, exp_data;
    logic [4:0]  exp_rd;
    bit          uexc, exc_path, fab, rab, ab;
    int          rdy_cyc, wb_cyc, k, last, flush_cyc, reset_cyc;

    if (div) begin
      uexc = (b == 0) || force_exc;
      res  = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
    end else begin
      uexc = force_exc;
      res  = a * b;
    end
    rdy_cyc = (lat < 0) ? 32'h4000_0000 : 1 + lat;
    if (rdy_cyc <= 1 + TIMEOUT) begin
      wb_cyc   = rdy_cyc + 1;
      exc_path = uexc;
    end else begin
      wb_cyc   = TIMEOUT + 2;
      exc_path = 1'b1;
    end
    exp_rd   = exc_path ? 5'd30 : rd;
    exp_data = exc_path ? (div ? 32'd5 : 32'd4) : res;

    flush_cyc = (flush_in > wb_cyc) ? -1 : flush_in;
    reset_cyc = (reset_in > wb_cyc || reset_in < 1) ? -1 : reset_in;
    fab = (flush_cyc >= 0) && (flush_cyc < wb_cyc);
    rab = (reset_cyc >= 1) && !fab;
    if (!rab) reset_cyc = -1;
    if (fab || rab) begin
      k    = fab ? flush_cyc : reset_cyc;
      last = k + 2;
      if (lat >= 0 && rdy_cyc + 1 > last) last = rdy_cyc + 1;
    end else begin
      last = wb_cyc + 1;
    end

    for (int c = 0; c <= last; c++) begin
      @(posedge clock);
      #1;
      ab = (fab && (flush_cyc == 0 || c > flush_cyc)) || (rab && c > reset_cyc);
      reset          = (c == reset_cyc);
      flush          = (c == flush_cyc);
      op_valid       = !ab && (c <= wb_cyc) && (c != reset_cyc);
      is_div         = div;
      is_mult        = !div || both;
      x_operandA     = (c == 0) ? a  : $urandom;
      x_operandB     = (c == 0) ? b  : $urandom;
      x_rd           = (c == 0) ? rd : 5'($urandom);
      data_resultRDY = (c == rdy_cyc) || (stale && c == 1);
      data_result    = (c == rdy_cyc) ? res  : $urandom;
      data_exception = (c == rdy_cyc) ? uexc : 1'($urandom);
      @(negedge clock);
      if (c == reset_cyc) continue;
      if (ab)                check("status_idle", status_now(), st(0, 0, 0, 0, 0));
      else if (c == 0)       check("status_accept", status_now(), st(1, 0, 0, 0, 0));
      else if (c == 1)       check("status_start", status_now(), st(1, 1, !div, div, 0));
      else if (c < wb_cyc)   check("status_busy", status_now(), st(1, 1, 0, 0, 0));
      else if (c == wb_cyc)  check("status_wb", status_now(), st(0, 0, 0, 0, 1));
      else                   check("status_after", status_now(), st(0, 0, 0, 0, 0));
      if (!ab && c >= 1 && c <= wb_cyc) begin
        check("operandA", data_operandA, a);
        check("operandB", data_operandB, b);
      end
      if (!ab && c == wb_cyc) begin
        check("wb_rd", 32'(wb_rd), 32'(exp_rd));
        check("wb_data", wb_data, exp_data);
      end
      if (rab && c == reset_cyc + 1) begin
        check("rst_operandA", data_operandA, 32'd0);
        check("rst_operandB", data_operandB, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
      end
    end
    reset          = 1'b0;
    flush          = 1'b0;
    op_valid       = 1'b0;
    data_resultRDY = 1'b0;
  endtask

  initial begin
    bit          div, both, fexc, stale;
    logic [31:0] a, b;
    int          lat, fl, rs;

    reset = 1'b1; op_valid = 1'b0; is_mult = 1'b0; is_div = 1'b0; flush = 1'b0;
    x_operandA = '0; x_operandB = '0; x_rd = '0;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_status", status_now(), st(0, 0, 0, 0, 0));
    check("reset_operandA", data_operandA, 32'd0);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);

    run_op(1, 0, 32'd100, 32'hFFFF_FFF9, 5'd5, 33, 0, -1, -1, 0);  // -14
    run_op(1, 0, 32'd9, 32'd0, 5'd3, 33, 0, -1, -1, 1);             // divide by zero
    run_op(0, 0, 32'h7FFF_FFFF, 32'd2, 5'd8, 6, 1, -1, -1, 0);      // mult overflow
    run_op(0, 0, 32'd11, 32'd13, 5'd9, -1, 0, -1, -1, 0);           // stuck mult
    run_op(1, 0, 32'd11, 32'd13, 5'd9, -1, 0, -1, -1, 0);           // stuck div
    run_op(1, 0, 32'd50, 32'd3, 5'd7, 33, 0, 12, -1, 0);            // flush in BUSY
    run_op(1, 0, 32'd20, 32'd4, 5'd10, 33, 0, -1, -1, 0);           // re-pulse, 5
    run_op(1, 0, 32'd77, 32'd7, 5'd4, 33, 0, -1, 14, 0);            // reset in BUSY
    run_op(0, 0, 32'd3, 32'd4, 5'd2, 3, 0, -1, -1, 0);              // 12
    run_op(0, 0, 32'd6, 32'd7, 5'd11, 4, 0, 6, -1, 0);              // flush in WB
    run_op(0, 0, 32'd5, 32'd5, 5'd0, 2, 0, -1, -1, 0);              // rd = $0
    run_op(1, 1, 32'd81, 32'd9, 5'd12, 5, 0, -1, -1, 0);            // both set, div wins
    run_op(0, 0, 32'd1, 32'd1, 5'd1, 3, 0, 0, -1, 0);               // flush in IDLE
    run_op(1, 0, 32'd64, 32'd8, 5'd13, 40, 0, -1, -1, 0);           // ready on last BUSY cycle
    run_op(1, 0, 32'd64, 32'd8, 5'd13, 41, 0, -1, -1, 0);           // one cycle too late
    run_op(0, 0, 32'd7, 32'd9, 5'd14, 1, 0, 1, -1, 0);              // flush in START

    for (int i = 0; i < 30; i++) begin
      both  = ($urandom_range(0, 3) == 0);
      div   = both || ($urandom_range(0, 1) == 1);
      a     = 32'($urandom_range(0, 100000));
      if ($urandom_range(0, 1) == 1) a = -a;
      b     = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) b = -b;
      if (!div) begin a = $urandom; b = $urandom; end
      lat   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 45);
      fexc  = ($urandom_range(0, 3) == 0);
      stale = ($urandom_range(0, 1) == 1);
      fl    = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1;
      rs    = (fl < 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : -1;
      run_op(div, both, a, b, 5'($urandom), lat, fexc, fl, rs, stale);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
